// File: rtl/ult_pkg.sv
// Shared constants, state encoding and small helpers for the ultrasonic ranging block.
package ult_pkg;

    localparam int CLK_HZ_DEF    = 12_000_000;
    localparam int TRIG_US_DEF   = 10;
    localparam int PERIOD_MS_DEF = 60;
    localparam int CM_US_DEF     = 58;
    localparam int SCAN_US_DEF   = 1000;

    localparam int US_CNT     = CLK_HZ_DEF / 1_000_000;
    localparam int CM_CNT     = US_CNT * CM_US_DEF;
    localparam int TRIG_CNT   = US_CNT * TRIG_US_DEF;
    localparam int PERIOD_CNT = US_CNT * 1000 * PERIOD_MS_DEF;
    localparam int SCAN_CNT   = US_CNT * SCAN_US_DEF;

    // Active-low segment codes, bit order {dp,g,f,e,d,c,b,a}
    localparam logic [7:0] SEG_0   = 8'hC0;
    localparam logic [7:0] SEG_1   = 8'hF9;
    localparam logic [7:0] SEG_2   = 8'hA4;
    localparam logic [7:0] SEG_3   = 8'hB0;
    localparam logic [7:0] SEG_4   = 8'h99;
    localparam logic [7:0] SEG_5   = 8'h92;
    localparam logic [7:0] SEG_6   = 8'h82;
    localparam logic [7:0] SEG_7   = 8'hF8;
    localparam logic [7:0] SEG_8   = 8'h80;
    localparam logic [7:0] SEG_9   = 8'h90;
    localparam logic [7:0] SEG_OFF = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MEAS = 2'd1,
        ST_HOLD = 2'd2
    } meas_state_t;

    function automatic logic [7:0] seg_code(input logic [3:0] d);
        logic [7:0] c;
        case (d)
            4'd0:    c = SEG_0;
            4'd1:    c = SEG_1;
            4'd2:    c = SEG_2;
            4'd3:    c = SEG_3;
            4'd4:    c = SEG_4;
            4'd5:    c = SEG_5;
            4'd6:    c = SEG_6;
            4'd7:    c = SEG_7;
            4'd8:    c = SEG_8;
            4'd9:    c = SEG_9;
            default: c = SEG_OFF;
        endcase
        return c;
    endfunction

    // Four-digit BCD increment that sticks at 9999
    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        carry;
        r     = v;
        carry = 1'b1;
        if (v != 16'h9999) begin
            for (int i = 0; i < 4; i++) begin
                if (carry) begin
                    if (r[i*4 +: 4] == 4'd9) begin
                        r[i*4 +: 4] = 4'd0;
                    end else begin
                        r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
                        carry       = 1'b0;
                    end
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/ult_seg_scan.sv
// Four-digit multiplexed seven-segment scanner; dig/smg are registered and active-low.
module seg_scan
    import ult_pkg::*;
#(
    parameter int SCAN_N = SCAN_CNT
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [15:0] bcd,
    output logic [3:0]  dig,
    output logic [7:0]  smg
);

    localparam int SW = $clog2(SCAN_N + 1);

    logic [SW-1:0] scan_cnt;
    logic [1:0]    idx;
    logic [3:0]    digit;

    always_comb begin
        digit = 4'd0;
        case (idx)
            2'd0: digit = bcd[3:0];
            2'd1: digit = bcd[7:4];
            2'd2: digit = bcd[11:8];
            2'd3: digit = bcd[15:12];
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            scan_cnt <= SW'(SCAN_N - 1);
            idx      <= 2'd0;
            dig      <= 4'hF;
            smg      <= SEG_OFF;
        end else begin
            if (scan_cnt == '0) begin
                scan_cnt <= SW'(SCAN_N - 1);
                idx      <= idx + 2'd1;
            end else begin
                scan_cnt <= scan_cnt - SW'(1);
            end
            dig <= ~(4'b0001 << idx);
            smg <= seg_code(digit);
        end
    end

endmodule

// File: rtl/ult_top.sv
// Ultrasonic ranging top: periodic trigger, echo timing in centimetres, display scan.
//
// state   | meaning
// IDLE    | waiting for a synchronized echo rise
// MEAS    | echo high; counting centimetres, watching for timeout
// HOLD    | timed out with 9999 latched; waiting for echo to go low
module ult_top
    import ult_pkg::*;
#(
    parameter int CLK_HZ    = CLK_HZ_DEF,
    parameter int TRIG_US   = TRIG_US_DEF,
    parameter int PERIOD_MS = PERIOD_MS_DEF,
    parameter int CM_US     = CM_US_DEF,
    parameter int SCAN_US   = SCAN_US_DEF
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       echo,
    output logic       trig,
    output logic [3:0] dig,
    output logic [7:0] smg
);

    localparam int US_N     = CLK_HZ / 1_000_000;
    localparam int TRIG_N   = US_N * TRIG_US;
    localparam int PERIOD_N = US_N * 1000 * PERIOD_MS;
    localparam int SCAN_N   = US_N * SCAN_US;
    localparam int PW       = $clog2(PERIOD_N + 1);
    localparam int UW       = $clog2(US_N + 1);
    localparam int CW       = $clog2(CM_US + 1);

    logic [PW-1:0] per_cnt;
    logic          sync1, sync2, echo_d;
    logic          rise, fall;
    meas_state_t   state, state_nxt;
    logic          start, latch_cnt, latch_max;
    logic [UW-1:0] us_cnt;
    logic [CW-1:0] cm_cnt;
    logic [PW-1:0] tmo_cnt;
    logic          us_tick, cm_tick, tmo_done;
    logic [15:0]   bcd, bcd_nxt, disp;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            per_cnt <= PW'(PERIOD_N - 1);
            trig    <= 1'b0;
        end else begin
            per_cnt <= (per_cnt == '0) ? PW'(PERIOD_N - 1) : per_cnt - PW'(1);
            trig    <= (per_cnt >= PW'(PERIOD_N - TRIG_N));
        end
    end

    // Synchronizer resets high so an echo already in flight at reset release
    // is never mistaken for a fresh rise; the resulting fall in IDLE is ignored.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            sync1  <= 1'b1;
            sync2  <= 1'b1;
            echo_d <= 1'b1;
        end else begin
            sync1  <= echo;
            sync2  <= sync1;
            echo_d <= sync2;
        end
    end

    assign rise = sync2 & ~echo_d;
    assign fall = ~sync2 & echo_d;

    assign us_tick  = (state == ST_MEAS) && (us_cnt == '0);
    assign cm_tick  = us_tick && (cm_cnt == '0);
    assign tmo_done = (state == ST_MEAS) && (tmo_cnt == '0);
    assign bcd_nxt  = cm_tick ? bcd_inc(bcd) : bcd;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        latch_cnt = 1'b0;
        latch_max = 1'b0;
        case (state)
            ST_IDLE: begin
                if (rise) begin
                    start     = 1'b1;
                    state_nxt = ST_MEAS;
                end
            end
            ST_MEAS: begin
                if (tmo_done) begin
                    latch_max = 1'b1;
                    state_nxt = ST_HOLD;
                end else if (fall) begin
                    latch_cnt = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            ST_HOLD: begin
                if (!sync2) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // A tick landing on the fall cycle is included so exact multiples of a centimetre count fully.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            us_cnt  <= UW'(US_N - 1);
            cm_cnt  <= CW'(CM_US - 1);
            tmo_cnt <= PW'(PERIOD_N - 1);
            bcd     <= 16'h0000;
            disp    <= 16'h0000;
        end else begin
            if (start) begin
                us_cnt  <= UW'(US_N - 1);
                cm_cnt  <= CW'(CM_US - 1);
                tmo_cnt <= PW'(PERIOD_N - 1);
                bcd     <= 16'h0000;
            end else if (state == ST_MEAS) begin
                us_cnt  <= us_tick ? UW'(US_N - 1) : us_cnt - UW'(1);
                if (us_tick) begin
                    cm_cnt <= (cm_cnt == '0) ? CW'(CM_US - 1) : cm_cnt - CW'(1);
                end
                tmo_cnt <= tmo_cnt - PW'(1);
                bcd     <= bcd_nxt;
            end
            if (latch_cnt) begin
                disp <= bcd_nxt;
            end else if (latch_max) begin
                disp <= 16'h9999;
            end
        end
    end

    seg_scan #(
        .SCAN_N(SCAN_N)
    ) u_seg_scan (
        .clk  (clk),
        .rstn (rstn),
        .bcd  (disp),
        .dig  (dig),
        .smg  (smg)
    );

endmodule

// File: tb/tb_ult_top.sv
// Bench for ult_top at a scaled clock (2 MHz, 14 ms period) so full periods and timeouts fit a short run.
module tb_ult_top;

    localparam int TRIG_N   = 20;
    localparam int PERIOD_N = 28000;
    localparam int CM_N     = 116;
    localparam int SCAN_N   = 100;

    logic       clk  = 1'b0;
    logic       rstn = 1'b0;
    logic       echo = 1'b0;
    logic       trig;
    logic [3:0] dig;
    logic [7:0] smg;

    int checks = 0;
    int errors = 0;

    logic [7:0] seg_lut [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

    always #5 clk = ~clk;

    ult_top #(
        .CLK_HZ   (2_000_000),
        .TRIG_US  (10),
        .PERIOD_MS(14),
        .CM_US    (58),
        .SCAN_US  (50)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .echo (echo),
        .trig (trig),
        .dig  (dig),
        .smg  (smg)
    );

    // Behavioural model: echo width in clocks -> centimetres, timeout -> 9999.
    int          cyc    = 0;
    int          hi_cnt = 0;
    bit          armed  = 1'b0;
    logic [15:0] m_disp = 16'h0000;
    logic [15:0] m_prev = 16'h0000;
    int          win    = 0;

    function automatic logic [15:0] to_bcd(input int v);
        int x;
        x = (v > 9999) ? 9999 : v;
        return {4'(x / 1000), 4'((x / 100) % 10), 4'((x / 10) % 10), 4'(x % 10)};
    endfunction

    always @(posedge clk) begin
        if (!rstn) begin
            cyc    <= 0;
            hi_cnt <= 0;
            armed  <= 1'b0;
            m_disp <= 16'h0000;
            m_prev <= 16'h0000;
            win    <= 0;
        end else begin
            cyc <= cyc + 1;
            if (win > 0) win <= win - 1;
            if (!armed) begin
                if (!echo) begin
                    armed  <= 1'b1;
                    hi_cnt <= 0;
                end
            end else if (echo) begin
                if (hi_cnt + 1 >= PERIOD_N) begin
                    m_prev <= m_disp;
                    m_disp <= 16'h9999;
                    win    <= 8;
                    armed  <= 1'b0;
                    hi_cnt <= 0;
                end else begin
                    hi_cnt <= hi_cnt + 1;
                end
            end else if (hi_cnt > 0) begin
                m_prev <= m_disp;
                m_disp <= to_bcd(hi_cnt / CM_N);
                win    <= 8;
                hi_cnt <= 0;
            end
        end
    end

    int         exp_idx;
    logic [3:0] exp_dig;
    bit         exp_trig;
    logic [7:0] code_new, code_old;
    bit         prev_trig = 1'b0;
    int         last_rise = -1;
    int         hi_len    = 0;
    int         cad_n     = 0;

    task automatic monitor();
        forever begin
            @(negedge clk);
            if (!rstn || cyc < 1) begin
                prev_trig = 1'b0;
                last_rise = -1;
                hi_len    = 0;
            end else begin
                exp_idx  = ((cyc - 1) / SCAN_N) % 4;
                exp_dig  = ~(4'b0001 << exp_idx);
                exp_trig = ((cyc - 1) % PERIOD_N) < TRIG_N;
                code_new = seg_lut[m_disp[exp_idx*4 +: 4]];
                code_old = seg_lut[m_prev[exp_idx*4 +: 4]];

                checks++;
                if (trig !== exp_trig) begin
                    errors++;
                    $display("FAIL trig cyc=%0d got %b want %b", cyc, trig, exp_trig);
                end
                checks++;
                if (dig !== exp_dig) begin
                    errors++;
                    $display("FAIL dig cyc=%0d got %b want %b", cyc, dig, exp_dig);
                end
                checks++;
                if (smg !== code_new && !(win > 0 && smg === code_old)) begin
                    errors++;
                    $display("FAIL smg cyc=%0d got %h want %h", cyc, smg, code_new);
                end

                if (trig && !prev_trig) begin
                    if (last_rise >= 0) begin
                        checks++;
                        cad_n++;
                        if (cyc - last_rise != 28000) begin
                            errors++;
                            $display("FAIL trig_period got %0d want 28000", cyc - last_rise);
                        end
                    end
                    last_rise = cyc;
                    hi_len    = 0;
                end
                if (trig) hi_len++;
                if (!trig && prev_trig) begin
                    checks++;
                    if (hi_len != 20) begin
                        errors++;
                        $display("FAIL trig_high_len got %0d want 20", hi_len);
                    end
                end
                prev_trig = trig;
            end
        end
    endtask

    task automatic check_lit(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h want %h", name, got, want);
        end
    endtask

    // codes: hand-computed segment bytes, digit 3 in the top byte, units in the bottom byte
    task automatic check_display(input string tag, input logic [15:0] want, input logic [31:0] codes);
        logic [3:0] want_dig;
        logic [7:0] want_smg;
        bit         found;
        check_lit({tag, "_model"}, {16'h0, m_disp}, {16'h0, want});
        for (int k = 0; k < 4; k++) begin
            want_dig = ~(4'b0001 << k);
            want_smg = codes[k*8 +: 8];
            found    = 1'b0;
            for (int t = 0; t < 600 && !found; t++) begin
                @(negedge clk);
                if (dig == want_dig) found = 1'b1;
            end
            checks++;
            if (!found) begin
                errors++;
                $display("FAIL %s scan_timeout digit %0d got dig %b want %b", tag, k, dig, want_dig);
            end else if (smg !== want_smg) begin
                errors++;
                $display("FAIL %s digit %0d got smg %h want %h", tag, k, smg, want_smg);
            end
        end
    endtask

    task automatic pulse(input int clocks);
        @(negedge clk);
        echo = 1'b1;
        repeat (clocks) @(negedge clk);
        echo = 1'b0;
        repeat (20) @(negedge clk);
    endtask

    initial begin
        fork
            monitor();
        join_none

        rstn = 1'b0;
        echo = 1'b0;
        repeat (10) @(negedge clk);
        check_lit("reset_trig", {31'h0, trig}, 32'h0);
        check_lit("reset_dig", {28'h0, dig}, 32'hF);
        check_lit("reset_smg", {24'h0, smg}, 32'hFF);
        rstn = 1'b1;
        @(negedge clk);
        check_lit("first_dig", {28'h0, dig}, 32'hE);
        check_lit("first_smg", {24'h0, smg}, 32'hC0);
        repeat (20) @(negedge clk);

        pulse(60);
        check_display("short_echo", 16'h0000, 32'hC0C0C0C0);

        pulse(1160);
        check_display("ten_cm", 16'h0010, 32'hC0C0F9C0);

        pulse(24940);
        check_display("carry_215", 16'h0215, 32'hC0A4F992);

        pulse(232);
        check_display("two_cm", 16'h0002, 32'hC0C0C0A4);

        @(negedge clk);
        echo = 1'b1;
        repeat (28100) @(negedge clk);
        check_display("timeout_high", 16'h9999, 32'h90909090);
        echo = 1'b0;
        repeat (20) @(negedge clk);
        check_display("timeout_low", 16'h9999, 32'h90909090);

        pulse(232);
        check_display("rearm", 16'h0002, 32'hC0C0C0A4);

        @(negedge clk);
        echo = 1'b1;
        repeat (500) @(negedge clk);
        rstn = 1'b0;
        repeat (10) @(negedge clk);
        check_lit("midreset_trig", {31'h0, trig}, 32'h0);
        check_lit("midreset_dig", {28'h0, dig}, 32'hF);
        check_lit("midreset_smg", {24'h0, smg}, 32'hFF);
        rstn = 1'b1;
        @(negedge clk);
        check_lit("midreset_first_smg", {24'h0, smg}, 32'hC0);
        repeat (2000) @(negedge clk);
        echo = 1'b0;
        repeat (20) @(negedge clk);
        check_display("after_reset", 16'h0000, 32'hC0C0C0C0);

        checks++;
        if (cad_n < 1) begin
            errors++;
            $display("FAIL trig_cadence_seen got %0d want >=1", cad_n);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ult_top.md
# ult_top

Ultrasonic ranging top level for an HC-SR04-style sensor driving a 4-digit multiplexed seven-segment display. It issues a periodic trigger pulse and times the sensor's echo pulse. It converts the echo width to centimetres as a 4-digit BCD value and scans that value onto the display. It is the chip top of the ranging demo: `echo` comes from the sensor pin, `trig` goes to the sensor, and `dig`/`smg` go to the display.

## Interface
- `CLK_HZ`, 12_000_000, system clock frequency; all timing constants are derived from it.
- `TRIG_US`, 10, trigger pulse width in µs.
- `PERIOD_MS`, 60, measurement period (trigger to trigger).
- `CM_US`, 58, echo µs per centimetre.
- `SCAN_US`, 1000, dwell time per display digit.
- `clk`  in  1  system clock (12 MHz).
- `rstn`  in  1  reset; synchronous, active-low.
- `echo`  in  1  sensor echo, asynchronous; high while sound is in flight.
- `trig`  out  1  sensor trigger, active-high pulse.
- `dig`  out  4  digit select, active-low one-hot; `dig[0]` is the units digit.
- `smg`  out  8  segments, active-low; bit order `{dp,g,f,e,d,c,b,a}`.

## Operation
- **Echo input:** `echo` passes through a 2-flop synchronizer. Rising and falling edges are detected on the synchronized signal.
- **Tick generators:**
  - `us_tick`: one pulse every CLK_HZ/1e6 clocks (12).
  - `cm_tick`: one pulse every CM_US `us_tick`s (696 clocks).
- **Trigger:** a free-running period counter asserts `trig` for TRIG_US at the start of each PERIOD_MS window, then holds it low for the rest of the window. The first trigger begins 1 clock after reset release.
- **Measurement state machine:** IDLE → MEAS on echo rise; MEAS → IDLE on echo fall.
  - On echo rise: clear the 4-digit BCD counter and the `cm_tick` prescaler.
  - In MEAS: each `cm_tick` increments the BCD counter. Each digit wraps 9→0 with a carry into the next digit. The counter saturates at 9999.
  - On echo fall: copy the BCD counter into the display register.
  - An echo edge arriving while the trigger is still high is honoured normally.
- **Truncation:** echo widths shorter than 58 µs yield 0000, and partial centimetres are truncated.
- **Timeout:** if echo stays high for a whole PERIOD_MS window, the state machine latches 9999 into the display register and returns to IDLE. It then waits for the echo to fall before accepting a new rise.
- **Display scan:** a 2-bit digit index advances every SCAN_US.
  - `dig` is the active-low one-hot of the index.
  - `smg` is the seven-segment code of the selected display-register digit; dp is always off (bit 7 = 1).
  - Codes, active-low: 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90.
  - All four digits are shown, including leading zeros.
- **Reset mid-operation:** any measurement in progress is aborted, and the display register is cleared to 0000.

## Timing
- **Reset values:** `trig`=0, `dig`=4'b1111, `smg`=8'hFF, display register=0000, state=IDLE.
- **Outputs:** all are registered.
- **Display scan timing:**
  - First digit scan: `dig`=1110 on the first clock after reset release.
  - A display-register update becomes visible on `smg` no later than the next clock.
- **Echo path latency:** 2 clocks of synchronizer delay plus 1 clock of edge detection. Measurement resolution is ±1 `cm_tick`.
- **`trig` high time:** exactly TRIG_US × 12 = 120 clocks at the defaults.
- **Period:** 720 000 clocks at the defaults.

## Structure
- **Shared package `ult_pkg`:**
  - Seven-segment code constants.
  - Derived clock-count constants (`US_CNT`, `CM_CNT`, `TRIG_CNT`, `PERIOD_CNT`, `SCAN_CNT`).
  - The state enum.
- **Sub-module `seg_scan`:** inputs are the 16-bit BCD value, `clk` and `rstn`; outputs are `dig` and `smg`.
- **Top level:** trigger generation, synchronizer, measurement state machine and BCD counter stay in the top.

## Test plan
- **Reset:** hold `rstn`=0 for 10 clocks → `trig`=0, `dig`=1111, `smg`=FF. After release, `dig`=1110 and `smg`=C0 (0000 displayed).
- **Short echo:** echo high for 30 µs → display stays 0000 (below one centimetre).
- **10 cm:** echo high for 580 µs → display 0010. When `dig`=1101 is scanned, `smg`=F9.
- **Carry and latch:** echo high for 12 470 µs → display 0215. A follow-up echo of 116 µs → display 0002.
- **Trigger cadence:** run for 2 periods → `trig` is high for 120 clocks, with rising edges 720 000 clocks apart.
- **Timeout and mid-measurement reset:**
  - Echo held high for 65 ms → display 9999.
  - Assert reset mid-echo → display returns to 0000, and no latch occurs on the subsequent echo fall.
